gate_tt_sweeper: RTL
====================

# gate_tt_sweeper

Stimulus-and-capture stage that sits directly upstream of a synthesized 4-input truth-table gate netlist such as `gate`. It drives all 16 input combinations into the gate's inputs and samples the gate's single output after a fixed settle time. It assembles the observed 16-bit truth table and compares it against an expected table. It is the on-chip/bench harness that qualifies each ABC/yosys gate design against its target truth table.

## Interface
Parameters:
- `TT_EXPECT`, 16'hA960, expected truth table in the yosys_tt bit order defined under Operation.
- `SETTLE_CYCLES`, 2, cycles each vector is held before sampling; legal range 1..15.

Ports:
- `clk`  in  1  the single clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request a sweep; accepted only in IDLE or on the DONE cycle.
- `abort`  in  1  cancel a sweep in progress.
- `gate_in`  out  4  vector to the gate; bit3 → `_0`, bit2 → `_1`, bit1 → `_2`, bit0 → `_3`.
- `gate_out`  in  1  gate output `_4`.
- `busy`  out  1  high while the sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `tt_obs`  out  16  observed truth table.
- `mismatch_cnt`  out  5  number of sampled bits differing from `TT_EXPECT` (0..16).
- `pass`  out  1  `tt_obs == TT_EXPECT`; valid from `done` until the next `start`.

## Operation
- Bit order: for vector v = `gate_in` (`_0` is MSB), the gate's expected output is `TT_EXPECT[15-v]`. Example: v=0 maps to bit15. The sample is stored in `tt_obs[15-v]`.
- FSM states are IDLE, DRIVE and DONE.
- IDLE:
  - On `start`, clear `tt_obs`, `mismatch_cnt` and `pass`.
  - Set v=0, load the settle counter with `SETTLE_CYCLES-1`, and go to DRIVE.
- DRIVE:
  - `gate_in`=v, `busy`=1, and the counter decrements each cycle.
  - On the edge where the counter is 0, sample `gate_out` into `tt_obs[15-v]`.
  - If the sample differs from the expected bit, increment `mismatch_cnt`. `mismatch_cnt` is 5 bits and cannot wrap.
  - If v=15, go to DONE. Otherwise v←v+1, reload the counter, and stay in DRIVE.
- DONE: lasts one cycle. `done`=1, `busy`=0, `pass` updates, `gate_in` returns to 0, then the FSM goes to IDLE.
  - `start` on the DONE cycle is accepted and goes straight to DRIVE, with the same clears as in IDLE.
- `start` while in DRIVE is ignored.
- `abort` in DRIVE or DONE:
  - Next state is IDLE with `gate_in`=0.
  - `tt_obs`, `mismatch_cnt` and `pass` are cleared to 0, and no `done` pulse is produced.
  - If `abort` and `start` are asserted together, `abort` wins.
- `tt_obs`, `mismatch_cnt` and `pass` hold their values in IDLE until the next accepted `start` or `abort`.

## Timing
- Reset (`rst_n`=0 at an edge), applied at any time including mid-sweep, gives: state IDLE, `gate_in`=0, `busy`=0, `done`=0, `tt_obs`=0, `mismatch_cnt`=0, `pass`=0.
- If `start` is sampled at edge 0:
  - `busy` rises after edge 0.
  - Each vector is held for S=`SETTLE_CYCLES` cycles.
  - `done` is high in the cycle following edge 16·S.
  - Latency from start to `done` is 16·S+1 cycles. With the default S=2 this is 33.
- All outputs are registered. `gate_out` is treated as combinational from `gate_in`.

## Configuration
- Macro: `GATE_SWEEP_SYNC_EN`.
- Defined:
  - `gate_out` passes through a 2-flop synchronizer before sampling.
  - Each vector is held for S+2 cycles, sampled on the last of them.
  - Latency is 16·(S+2)+1 cycles.
  - The synchronizer flops reset to 0.
- Undefined: `gate_out` is sampled directly, and latency is as specified under Timing.

## Structure
- Package `gate_sweep_pkg` holds:
  - the state enum (IDLE/DRIVE/DONE);
  - `N_IN`=4 and `TT_W`=16;
  - the function `tt_idx(v)` = 15-v.
- Sub-module `gate_sweep_sync` is the 2-flop synchronizer, instantiated only under `GATE_SWEEP_SYNC_EN`.

## Test plan
All scenarios use a behavioural model of the 0xA960 gate and S=2 unless stated otherwise.
- Correct gate, `start` pulse at edge 0 → `done` in cycle 33, `tt_obs`=16'hA960, `mismatch_cnt`=0, `pass`=1. `gate_in` steps 0..15, each value held 2 cycles.
- `gate_out` stuck at 0 → `tt_obs`=16'h0000, `mismatch_cnt`=6, `pass`=0. With the model inverted instead → `tt_obs`=16'h569F, `mismatch_cnt`=16.
- `abort` at vector 7, with `start` asserted in the same cycle → next cycle: `busy`=0, `gate_in`=0, `tt_obs`=0. No `done` pulse follows.
- `start` re-pulsed mid-sweep → ignored, and `done` still lands in cycle 33. `start` on the DONE cycle → a new sweep begins the next cycle, and `tt_obs` is cleared.
- `rst_n` low for one edge at vector 9 → all outputs return to their reset values. A subsequent sweep passes.
- S=1 with `GATE_SWEEP_SYNC_EN` defined → each vector is held 3 cycles, `done` in cycle 49, `pass`=1.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared types, widths and helpers for the gate truth-table sweeper.
package gate_sweep_pkg;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned TT_W  = 16;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned MIS_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_e;

  // Truth-table bit position for input vector v (vector 0 lands in the MSB).
  function automatic logic [N_IN-1:0] tt_idx(input logic [N_IN-1:0] v);
    return N_IN'(TT_W - 1) - v;
  endfunction

endpackage

// File: rtl/gate_sweep_sync.sv
// Two-flop synchronizer for the gate output; only built with GATE_SWEEP_SYNC_EN.
`ifdef GATE_SWEEP_SYNC_EN
module gate_sweep_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture, both stages cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/gate_tt_sweeper.sv
// Drives all 16 vectors into a 4-input gate, captures its truth table and
// compares it against TT_EXPECT.
// Optional macro GATE_SWEEP_SYNC_EN: resample gate_out through two flops and
// stretch each vector by two cycles to cover the added delay.
module gate_tt_sweeper
  import gate_sweep_pkg::*;
#(
  parameter logic [TT_W-1:0] TT_EXPECT     = 16'hA960,
  parameter int unsigned     SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  gate_in,
  input  logic             gate_out,
  output logic             busy,
  output logic             done,
  output logic [TT_W-1:0]  tt_obs,
  output logic [MIS_W-1:0] mismatch_cnt,
  output logic             pass
);

  logic sample_bit;

`ifdef GATE_SWEEP_SYNC_EN
  localparam int unsigned HOLD = SETTLE_CYCLES + 2;

  gate_sweep_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gate_out),
    .q     (sample_bit)
  );
`else
  localparam int unsigned HOLD = SETTLE_CYCLES;

  assign sample_bit = gate_out;
`endif

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD - 1);
  localparam logic [N_IN-1:0]  LAST_VEC   = N_IN'(TT_W - 1);

  sweep_state_e    state;
  logic [CNT_W-1:0] settle_cnt;
  logic [N_IN-1:0]  samp_idx;
  logic             exp_bit;
  logic             miss;
  logic [TT_W-1:0]  tt_new;

  // Truth table as it would look with the current sample merged in.
  always_comb begin
    samp_idx         = tt_idx(gate_in);
    exp_bit          = TT_EXPECT[samp_idx];
    miss             = sample_bit ^ exp_bit;
    tt_new           = tt_obs;
    tt_new[samp_idx] = sample_bit;
  end

  // Sweep sequencer: state, vector, settle counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      settle_cnt   <= '0;
      gate_in      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tt_obs       <= '0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort beats start and discards any partial result.
        state        <= ST_IDLE;
        settle_cnt   <= '0;
        gate_in      <= '0;
        busy         <= 1'b0;
        tt_obs       <= '0;
        mismatch_cnt <= '0;
        pass         <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state        <= ST_DRIVE;
              settle_cnt   <= CNT_RELOAD;
              gate_in      <= '0;
              busy         <= 1'b1;
              tt_obs       <= '0;
              mismatch_cnt <= '0;
              pass         <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_DRIVE: begin
            if (settle_cnt == '0) begin
              tt_obs <= tt_new;
              if (miss && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + MIS_W'(1);
              end
              if (gate_in == LAST_VEC) begin
                state   <= ST_DONE;
                gate_in <= '0;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= (tt_new == TT_EXPECT);
              end else begin
                gate_in    <= gate_in + N_IN'(1);
                settle_cnt <= CNT_RELOAD;
              end
            end else begin
              settle_cnt <= settle_cnt - CNT_W'(1);
            end
          end
          default: begin
            state   <= ST_IDLE;
            gate_in <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
